// File: rtl/fifo_multi_channel_pkg.sv
// Shared types and helpers for the multi-channel register FIFO.
// Optional threshold flags are enabled with the FIFO_MC_THRESHOLD_EN macro.
package fifo_multi_channel_pkg;

  localparam int unsigned FIFO_MC_DEF_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_MC_DEF_CHANNELS   = 4;

`ifdef FIFO_MC_THRESHOLD_EN
  localparam bit FIFO_MC_THRESHOLD = 1'b1;
`else
  localparam bit FIFO_MC_THRESHOLD = 1'b0;
`endif

  typedef logic [FIFO_MC_DEF_ADDR_WIDTH:0] fifo_mc_level_t;
  typedef logic [FIFO_MC_DEF_CHANNELS-1:0][FIFO_MC_DEF_ADDR_WIDTH:0] fifo_mc_level_vec_t;
  typedef logic [$clog2(FIFO_MC_DEF_CHANNELS)-1:0] fifo_mc_ch_idx_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_multi_channel_reg_sp_rf.sv
// Flat storage array for all channels: synchronous write, asynchronous read.
module reg_sp_rf
  import fifo_multi_channel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned ADDR_WIDTH_P = 6
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH_P-1:0] waddr,
  input  logic [DATA_WIDTH_P-1:0] wdata,
  input  logic [ADDR_WIDTH_P-1:0] raddr,
  output logic [DATA_WIDTH_P-1:0] rdata
);

  logic [DATA_WIDTH_P-1:0] mem_q [fifo_depth(ADDR_WIDTH_P)];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_multi_channel.sv
// Multi-channel FIFO: independent circular queues sharing one register file.
// Define FIFO_MC_THRESHOLD_EN to add cr_almost_full_lvl / almost_full.
module fifo_multi_channel
  import fifo_multi_channel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P     = 32,
  parameter int unsigned ADDR_WIDTH_P     = 4,
  parameter int unsigned NR_OF_CHANNELS_P = 4,
  parameter int unsigned CH_WIDTH_P       = $clog2(NR_OF_CHANNELS_P)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ing_enable,
  input  logic [CH_WIDTH_P-1:0]                        ing_channel,
  input  logic [DATA_WIDTH_P-1:0]                      ing_data,
  output logic [NR_OF_CHANNELS_P-1:0]                  ing_full,
  input  logic                                         egr_enable,
  input  logic [CH_WIDTH_P-1:0]                        egr_channel,
  output logic [DATA_WIDTH_P-1:0]                      egr_data,
  output logic [NR_OF_CHANNELS_P-1:0]                  egr_empty,
  output logic [NR_OF_CHANNELS_P-1:0][ADDR_WIDTH_P:0]  sr_fill_level
`ifdef FIFO_MC_THRESHOLD_EN
  ,
  input  logic [ADDR_WIDTH_P:0]                        cr_almost_full_lvl,
  output logic [NR_OF_CHANNELS_P-1:0]                  almost_full
`endif
);

  localparam int unsigned RF_AW = ADDR_WIDTH_P + CH_WIDTH_P;
  localparam logic [ADDR_WIDTH_P:0] DEPTH = (ADDR_WIDTH_P+1)'(fifo_depth(ADDR_WIDTH_P));

  logic [NR_OF_CHANNELS_P-1:0][ADDR_WIDTH_P-1:0] wr_ptr_all, rd_ptr_all;
  logic [NR_OF_CHANNELS_P-1:0]                   push_all;
  logic [ADDR_WIDTH_P-1:0]                       wr_sel, rd_sel;
  logic [RF_AW-1:0]                              rf_waddr, rf_raddr;

  // Channel decode by equality: out-of-range selects match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int unsigned c = 0; c < NR_OF_CHANNELS_P; c++) begin
      if (ing_channel == CH_WIDTH_P'(c)) wr_sel = wr_ptr_all[c];
      if (egr_channel == CH_WIDTH_P'(c)) rd_sel = rd_ptr_all[c];
    end
  end

  assign rf_waddr = {ing_channel, wr_sel};
  assign rf_raddr = {egr_channel, rd_sel};

  reg_sp_rf #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ADDR_WIDTH_P (RF_AW)
  ) u_rf (
    .clk   (clk),
    .we    (|push_all),
    .waddr (rf_waddr),
    .wdata (ing_data),
    .raddr (rf_raddr),
    .rdata (egr_data)
  );

  for (genvar c = 0; c < NR_OF_CHANNELS_P; c++) begin : g_ch
    logic [ADDR_WIDTH_P-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH_P:0]   level_q, level_d;
    logic                    empty_q, empty_d;
    logic                    push, pop, full;

    // A full channel still takes a push when it is being popped in the same cycle.
    assign full = (level_q == DEPTH) && !(egr_enable && (egr_channel == CH_WIDTH_P'(c)));
    assign push = ing_enable && (ing_channel == CH_WIDTH_P'(c)) && !full;
    assign pop  = egr_enable && (egr_channel == CH_WIDTH_P'(c)) && !empty_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      empty_d  = empty_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10: begin
          level_d = level_q + 1'b1;
          empty_d = 1'b0;
        end
        2'b01: begin
          level_d = level_q - 1'b1;
          if (level_q == (ADDR_WIDTH_P+1)'(1)) empty_d = 1'b1;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        empty_q  <= 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        empty_q  <= empty_d;
      end
    end

    assign ing_full[c]      = full;
    assign egr_empty[c]     = empty_q;
    assign sr_fill_level[c] = level_q;
    assign wr_ptr_all[c]    = wr_ptr_q;
    assign rd_ptr_all[c]    = rd_ptr_q;
    assign push_all[c]      = push;

`ifdef FIFO_MC_THRESHOLD_EN
    logic almost_full_q, almost_full_d;

    assign almost_full_d = (level_d >= cr_almost_full_lvl);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) almost_full_q <= 1'b0;
      else        almost_full_q <= almost_full_d;
    end

    assign almost_full[c] = almost_full_q;
`endif
  end

endmodule
